// File: rtl/ad9364_dac_pkg.sv
// Shared encodings and pattern constants for the AD9364 transmit scheduler.
package ad9364_dac_pkg;

    localparam int DW_DEFAULT = 12;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'b00,
        SRC_S0   = 2'b01,
        SRC_S1   = 2'b10,
        SRC_PAT  = 2'b11
    } src_sel_e;

    typedef enum logic [1:0] {
        PAT_E0 = 2'd0,
        PAT_E1 = 2'd1,
        PAT_E2 = 2'd2
    } pat_idx_e;

    // Pattern entries as 12-bit two's complement I/Q codes.
    localparam logic [11:0] PAT0_I = 12'o3777;
    localparam logic [11:0] PAT0_Q = 12'o3737;
    localparam logic [11:0] PAT1_I = 12'o0000;
    localparam logic [11:0] PAT1_Q = 12'o1737;
    localparam logic [11:0] PAT2_I = 12'o4000;
    localparam logic [11:0] PAT2_Q = 12'o0000;

endpackage

// File: rtl/ad9364_dac_pattern_gen.sv
// Three-entry I/Q test pattern source; only instantiated when AD9364_DAC_PATTERN_EN is defined.
module ad9364_dac_pattern_gen
    import ad9364_dac_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    input  logic          advance,
    input  logic          r1_mode,
    output logic [DW-1:0] pat_i1,
    output logic [DW-1:0] pat_q1,
    output logic [DW-1:0] pat_i2,
    output logic [DW-1:0] pat_q2
);

    pat_idx_e    idx_q;
    pat_idx_e    idx_d;
    pat_idx_e    cur;
    logic [11:0] i_raw;
    logic [11:0] q_raw;

    always_comb begin
        // A restart presents entry 0 in the same cycle it is requested.
        cur   = restart ? PAT_E0 : idx_q;
        idx_d = idx_q;
        if (advance) begin
            case (cur)
                PAT_E0:  idx_d = PAT_E1;
                PAT_E1:  idx_d = PAT_E2;
                default: idx_d = PAT_E0;
            endcase
        end else if (restart) begin
            idx_d = PAT_E0;
        end

        case (cur)
            PAT_E0: begin
                i_raw = PAT0_I;
                q_raw = PAT0_Q;
            end
            PAT_E1: begin
                i_raw = PAT1_I;
                q_raw = PAT1_Q;
            end
            default: begin
                i_raw = PAT2_I;
                q_raw = PAT2_Q;
            end
        endcase

        pat_i1 = DW'($signed(i_raw));
        pat_q1 = DW'($signed(q_raw));
        pat_i2 = r1_mode ? '0 : pat_i1;
        pat_q2 = r1_mode ? '0 : pat_q1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= PAT_E0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/ad9364_dac_scheduler.sv
// AD9364 transmit slot scheduler: dac_valid cadence, source arbitration and underflow counting.
// Optional pattern source compiled in with AD9364_DAC_PATTERN_EN.
module ad9364_dac_scheduler
    import ad9364_dac_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int UF_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dac_enable,
    input  logic            dac_r1_mode,
    input  logic [1:0]      src_sel,
    input  logic            s0_valid,
    input  logic [4*DW-1:0] s0_data,
    output logic            s0_ready,
    input  logic            s1_valid,
    input  logic [4*DW-1:0] s1_data,
    output logic            s1_ready,
    input  logic            underflow_clr,
    output logic            dac_valid,
    output logic [DW-1:0]   dac_data_i1,
    output logic [DW-1:0]   dac_data_q1,
    output logic [DW-1:0]   dac_data_i2,
    output logic [DW-1:0]   dac_data_q2,
    output logic [1:0]      src_active,
    output logic [UF_W-1:0] underflow_cnt
);

    logic [1:0]      cnt_q, cnt_d;
    logic            r1_q, r1_d;
    logic [1:0]      src_q, src_d;
    logic            valid_q, valid_d;
    logic [4*DW-1:0] data_q, data_d;
    logic [UF_W-1:0] uf_q, uf_d;

    logic            slot;
    logic            underflow;
    logic [1:0]      wrap_at;
    logic [4*DW-1:0] sel_lanes;
    logic [4*DW-1:0] pat_lanes;

`ifdef AD9364_DAC_PATTERN_EN
    logic [DW-1:0] pat_i1, pat_q1, pat_i2, pat_q2;

    ad9364_dac_pattern_gen #(
        .DW (DW)
    ) u_pattern_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (src_q != SRC_PAT),
        .advance (slot && (src_sel == SRC_PAT)),
        .r1_mode (dac_r1_mode),
        .pat_i1  (pat_i1),
        .pat_q1  (pat_q1),
        .pat_i2  (pat_i2),
        .pat_q2  (pat_q2)
    );

    assign pat_lanes = {pat_i1, pat_q1, pat_i2, pat_q2};
`else
    assign pat_lanes = '0;
`endif

    always_comb begin
        slot     = !rst && dac_enable && (cnt_q == 2'd0);
        s0_ready = slot && (src_sel == SRC_S0);
        s1_ready = slot && (src_sel == SRC_S1);

        // Mode is only re-sampled at a slot so the running period always completes.
        r1_d    = slot ? dac_r1_mode : r1_q;
        wrap_at = r1_d ? 2'd1 : 2'd3;
        if (!dac_enable) begin
            cnt_d = 2'd0;
        end else if (cnt_q == wrap_at) begin
            cnt_d = 2'd0;
        end else begin
            cnt_d = cnt_q + 2'd1;
        end

        src_d     = slot ? src_sel : src_q;
        underflow = (s0_ready && !s0_valid) || (s1_ready && !s1_valid);

        case (src_sel)
            SRC_S0:  sel_lanes = s0_valid ? s0_data : '0;
            SRC_S1:  sel_lanes = s1_valid ? s1_data : '0;
            SRC_PAT: sel_lanes = pat_lanes;
            default: sel_lanes = '0;
        endcase
        if (dac_r1_mode) begin
            sel_lanes[2*DW-1:0] = '0;
        end

        data_d  = slot ? sel_lanes : data_q;
        valid_d = slot;

        if (underflow_clr) begin
            uf_d = underflow ? UF_W'(1) : '0;
        end else if (underflow && (uf_q != {UF_W{1'b1}})) begin
            uf_d = uf_q + UF_W'(1);
        end else begin
            uf_d = uf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            r1_q    <= 1'b1;
            src_q   <= SRC_ZERO;
            valid_q <= 1'b0;
            data_q  <= '0;
            uf_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            r1_q    <= r1_d;
            src_q   <= src_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            uf_q    <= uf_d;
        end
    end

    assign dac_valid     = valid_q;
    assign dac_data_i1   = data_q[4*DW-1:3*DW];
    assign dac_data_q1   = data_q[3*DW-1:2*DW];
    assign dac_data_i2   = data_q[2*DW-1:DW];
    assign dac_data_q2   = data_q[DW-1:0];
    assign src_active    = src_q;
    assign underflow_cnt = uf_q;

endmodule

// File: tb/tb_ad9364_dac_scheduler.sv
// Randomized and directed bench for ad9364_dac_scheduler against a slot-time reference model.
module tb_ad9364_dac_scheduler;

    localparam int DW = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic            dac_enable;
    logic            dac_r1_mode;
    logic [1:0]      src_sel;
    logic            s0_valid, s1_valid;
    logic [4*DW-1:0] s0_data, s1_data;
    logic            s0_ready, s1_ready;
    logic            underflow_clr;
    logic            dac_valid;
    logic [DW-1:0]   dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2;
    logic [1:0]      src_active;
    logic [15:0]     underflow_cnt;

    logic            sat_s0_ready, sat_s1_ready, sat_dac_valid;
    logic [DW-1:0]   sat_i1, sat_q1, sat_i2, sat_q2;
    logic [1:0]      sat_src_active;
    logic [1:0]      sat_uf;

    always #5 clk = ~clk;

    ad9364_dac_scheduler #(.DW(DW), .UF_W(16)) dut (
        .clk(clk), .rst(rst), .dac_enable(dac_enable), .dac_r1_mode(dac_r1_mode),
        .src_sel(src_sel), .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
        .underflow_clr(underflow_clr), .dac_valid(dac_valid),
        .dac_data_i1(dac_data_i1), .dac_data_q1(dac_data_q1),
        .dac_data_i2(dac_data_i2), .dac_data_q2(dac_data_q2),
        .src_active(src_active), .underflow_cnt(underflow_cnt)
    );

    // Narrow counter instance so saturation is reachable in a short run.
    ad9364_dac_scheduler #(.DW(DW), .UF_W(2)) dut_sat (
        .clk(clk), .rst(rst), .dac_enable(dac_enable), .dac_r1_mode(dac_r1_mode),
        .src_sel(src_sel), .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(sat_s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(sat_s1_ready),
        .underflow_clr(underflow_clr), .dac_valid(sat_dac_valid),
        .dac_data_i1(sat_i1), .dac_data_q1(sat_q1),
        .dac_data_i2(sat_i2), .dac_data_q2(sat_q2),
        .src_active(sat_src_active), .underflow_cnt(sat_uf)
    );

`ifdef AD9364_DAC_PATTERN_EN
    localparam logic [11:0] PAT_I [3] = '{12'o3777, 12'o0000, 12'o4000};
    localparam logic [11:0] PAT_Q [3] = '{12'o3737, 12'o1737, 12'o0000};
    int m_pos;
`endif

    int              n_assert = 0;
    int              n_fail   = 0;
    int              t;
    int              next_slot_t;
    logic            m_valid;
    logic [4*DW-1:0] m_lanes;
    logic [1:0]      m_src;
    int              m_uf;
    int              m_uf2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit slot_now();
        return !rst && dac_enable && (t == next_slot_t);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_lanes = '0;
        m_src   = 2'b00;
        m_uf    = 0;
        m_uf2   = 0;
`ifdef AD9364_DAC_PATTERN_EN
        m_pos   = 0;
`endif
    endtask

    // One clock: check ready before the edge, advance the model, check registered outputs after it.
    task automatic tick();
        bit              slot;
        bit              uf_ev;
        logic [4*DW-1:0] l;
        #1;
        slot = slot_now();
        chk("s0_ready", s0_ready, slot && (src_sel == 2'b01));
        chk("s1_ready", s1_ready, slot && (src_sel == 2'b10));
        if (rst) begin
            model_reset();
            next_slot_t = t + 1;
        end else begin
            uf_ev = slot && (((src_sel == 2'b01) && !s0_valid) || ((src_sel == 2'b10) && !s1_valid));
            if (slot) begin
                l = '0;
                if (src_sel == 2'b01 && s0_valid) l = s0_data;
                if (src_sel == 2'b10 && s1_valid) l = s1_data;
`ifdef AD9364_DAC_PATTERN_EN
                if (src_sel == 2'b11) begin
                    if (m_src != 2'b11) m_pos = 0;
                    l = {PAT_I[m_pos], PAT_Q[m_pos], PAT_I[m_pos], PAT_Q[m_pos]};
                    m_pos = (m_pos + 1) % 3;
                end
`endif
                if (dac_r1_mode) l[2*DW-1:0] = '0;
                m_lanes     = l;
                m_src       = src_sel;
                next_slot_t = t + (dac_r1_mode ? 2 : 4);
            end
            if (!dac_enable) next_slot_t = t + 1;
            m_valid = slot;
            if (underflow_clr) begin
                m_uf  = uf_ev ? 1 : 0;
                m_uf2 = uf_ev ? 1 : 0;
            end else if (uf_ev) begin
                m_uf  = (m_uf  < 65535) ? m_uf  + 1 : 65535;
                m_uf2 = (m_uf2 < 3)     ? m_uf2 + 1 : 3;
            end
        end
        t++;
        @(posedge clk);
        #1;
        chk("dac_valid", dac_valid, m_valid);
        chk("lanes", {dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2}, m_lanes);
        chk("src_active", src_active, m_src);
        chk("underflow_cnt", underflow_cnt, m_uf);
        chk("underflow_cnt_narrow", sat_uf, m_uf2);
    endtask

    task automatic wait_slot(input string tag);
        int k = 0;
        while (!slot_now() && k < 8) begin
            tick();
            k++;
        end
        chk(tag, slot_now(), 1'b1);
    endtask

    initial begin
        rst = 1'b1; dac_enable = 1'b0; dac_r1_mode = 1'b1; src_sel = 2'b00;
        s0_valid = 1'b0; s1_valid = 1'b0; s0_data = '0; s1_data = '0; underflow_clr = 1'b0;
        t = 0; next_slot_t = 0;
        model_reset();
        @(posedge clk);
        #1;
        repeat (2) tick();

        // r1 cadence on the pattern source
        rst = 1'b0; dac_enable = 1'b1; dac_r1_mode = 1'b1; src_sel = 2'b11;
        repeat (12) tick();

        // r2 cadence streaming from stream 0; stream 1 offers data but must not drain
        dac_r1_mode = 1'b0; src_sel = 2'b01; s0_valid = 1'b1; s1_valid = 1'b1;
        s1_data = 48'hABC_DEF_123_456;
        for (int i = 0; i < 16; i++) begin
            s0_data = {12'(4*i), 12'(4*i+1), 12'(4*i+2), 12'(4*i+3)};
            tick();
        end

        // stream 1 underflows
        dac_r1_mode = 1'b1; src_sel = 2'b10; s1_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            wait_slot("uf_slot_wait");
            tick();
        end
        chk("uf_after_three", underflow_cnt, 16'd3);
        wait_slot("uf_clr_wait");
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        chk("uf_clr_with_underflow", underflow_cnt, 16'd1);
        for (int j = 0; j < 4; j++) begin
            wait_slot("uf_sat_wait");
            tick();
        end
        chk("uf_narrow_saturated", sat_uf, 2'd3);
        chk("uf_wide_count", underflow_cnt, 16'd5);
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        chk("uf_clr_alone", underflow_cnt, 16'd0);

        // mid-period change of source and mode
        src_sel = 2'b01; dac_r1_mode = 1'b1; s0_valid = 1'b1; s0_data = {$urandom, $urandom};
        wait_slot("mid_wait");
        tick();
        src_sel = 2'b11; dac_r1_mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s0_data = {$urandom, $urandom};
            tick();
        end

        // disable holds data and stops strobes
        src_sel = 2'b01;
        dac_enable = 1'b0;
        repeat (5) tick();
        dac_enable = 1'b1;
        repeat (6) tick();

        // reset mid-run
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (6) tick();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            dac_enable    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) dac_r1_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) src_sel = 2'($urandom_range(0, 3));
            s0_valid      = ($urandom_range(0, 3) != 0);
            s1_valid      = ($urandom_range(0, 3) != 0);
            s0_data       = {$urandom, $urandom};
            s1_data       = {$urandom, $urandom};
            underflow_clr = ($urandom_range(0, 15) == 0);
            rst           = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
